// File: rtl/collision_detector_pkg.sv
// collision_detector_pkg: shared game geometry constants and collision FSM encoding
package collision_detector_pkg;
  localparam int COORD_W = 10;
  localparam int TILE_SIZE = 32;
  localparam int CAR_WIDTH = 64;
  localparam int NUM_CARS = 8;
  typedef enum logic [1:0] {IDLE, SCAN, HIT, GRACE} state_t;
endpackage

// File: rtl/collision_box_compare.sv
// collision_box_compare: combinational 11-bit overlap test of a frog tile box against a car box
module collision_box_compare
  import collision_detector_pkg::*;
(
  input  logic [COORD_W-1:0] fx,
  input  logic [COORD_W-1:0] fy,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic               overlap
);
  logic [COORD_W:0] fx_w, fy_w, cx_w, cy_w;
  assign fx_w = {1'b0, fx};
  assign fy_w = {1'b0, fy};
  assign cx_w = {1'b0, cx};
  assign cy_w = {1'b0, cy};
  assign overlap = (fx_w < cx_w + (COORD_W + 1)'(CAR_WIDTH)) && (cx_w < fx_w + (COORD_W + 1)'(TILE_SIZE)) &&
                   (fy_w < cy_w + (COORD_W + 1)'(TILE_SIZE)) && (cy_w < fy_w + (COORD_W + 1)'(TILE_SIZE));
endmodule

// File: rtl/collision_detector.sv
// collision_detector: frame-synchronous serial frog/car overlap checker with hit pulse and grace period
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int NUM_CARS = collision_detector_pkg::NUM_CARS,
  parameter int HIT_CYCLES = 4,
  parameter int GRACE_FRAMES = 60
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Frame_Start,
  input  logic [COORD_W-1:0]          i_Frog_X,
  input  logic [COORD_W-1:0]          i_Frog_Y,
  input  logic [COORD_W*NUM_CARS-1:0] i_Car_X,
  input  logic [COORD_W*NUM_CARS-1:0] i_Car_Y,
  output logic                        o_Has_Collided,
  output logic [3:0]                  o_Hit_Car,
  output logic [7:0]                  o_Hit_Count,
  output logic                        o_Busy
);
  localparam int HW = HIT_CYCLES > 1 ? $clog2(HIT_CYCLES) : 1;
  localparam int GW = GRACE_FRAMES > 0 ? $clog2(GRACE_FRAMES + 1) : 1;
  state_t st, nxt;
  logic [COORD_W-1:0] fx, fy, cx, cy;
  logic [COORD_W*NUM_CARS-1:0] car_x, car_y;
  logic [3:0] idx;
  logic [HW-1:0] hc;
  logic [GW-1:0] gc;
  logic hit, last, hc_done;
  assign cx = car_x[COORD_W*idx +: COORD_W];
  assign cy = car_y[COORD_W*idx +: COORD_W];
  assign last = idx == 4'(NUM_CARS - 1);
  assign hc_done = hc == HW'(HIT_CYCLES - 1);
  collision_box_compare u_cmp (
    .fx(fx),
    .fy(fy),
    .cx(cx),
    .cy(cy),
    .overlap(hit)
  );
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = i_Frame_Start ? SCAN : IDLE;
      SCAN:    nxt = hit ? HIT : (last ? IDLE : SCAN);
      HIT:     nxt = hc_done ? (GRACE_FRAMES > 0 ? GRACE : IDLE) : HIT;
      GRACE:   nxt = (i_Frame_Start && gc == GW'(1)) ? IDLE : GRACE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      st <= IDLE;
      fx <= '0;
      fy <= '0;
      car_x <= '0;
      car_y <= '0;
      idx <= '0;
      hc <= '0;
      gc <= '0;
      o_Has_Collided <= 1'b0;
      o_Hit_Car <= '0;
      o_Hit_Count <= '0;
      o_Busy <= 1'b0;
    end else begin
      st <= nxt;
      o_Has_Collided <= nxt == HIT;
      o_Busy <= nxt == SCAN || nxt == HIT;
      if (st == IDLE && i_Frame_Start) begin
        fx <= i_Frog_X;
        fy <= i_Frog_Y;
        car_x <= i_Car_X;
        car_y <= i_Car_Y;
        idx <= '0;
      end
      if (st == SCAN) idx <= idx + 4'd1;
      if (st == SCAN && hit) begin
        o_Hit_Car <= idx;
        o_Hit_Count <= o_Hit_Count + 8'd1;
        hc <= '0;
      end
      if (st == HIT) hc <= hc + HW'(1);
      if (st == HIT && hc_done) gc <= GW'(GRACE_FRAMES);
      if (st == GRACE && i_Frame_Start) gc <= gc - GW'(1);
    end
  end
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: directed self-checking bench for the frame-synchronous collision checker
module tb_collision_detector;
  logic i_Clk = 1'b0;
  logic i_Rst = 1'b0;
  logic i_Frame_Start = 1'b0;
  logic [9:0] i_Frog_X = 10'd320;
  logic [9:0] i_Frog_Y = 10'd384;
  logic [79:0] i_Car_X = '0;
  logic [79:0] i_Car_Y = '0;
  logic o_Has_Collided;
  logic [3:0] o_Hit_Car;
  logic [7:0] o_Hit_Count;
  logic o_Busy;
  int n_cmp = 0;
  int n_bad = 0;
  int rise, width, busy_last, hits;
  collision_detector dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_Frame_Start(i_Frame_Start),
    .i_Frog_X(i_Frog_X),
    .i_Frog_Y(i_Frog_Y),
    .i_Car_X(i_Car_X),
    .i_Car_Y(i_Car_Y),
    .o_Has_Collided(o_Has_Collided),
    .o_Hit_Car(o_Hit_Car),
    .o_Hit_Count(o_Hit_Count),
    .o_Busy(o_Busy)
  );
  always #5 i_Clk = ~i_Clk;
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic set_car(input int k, input int x, input int y);
    i_Car_X[k*10 +: 10] = 10'(x);
    i_Car_Y[k*10 +: 10] = 10'(y);
  endtask
  task automatic do_reset();
    i_Car_X = '0;
    i_Car_Y = '0;
    i_Rst = 1'b1;
    tick();
    tick();
    i_Rst = 1'b0;
  endtask
  task automatic run_frame(input int rst_at, input int mv_at, output int r, output int w, output int b);
    r = -1;
    w = 0;
    b = -1;
    i_Frame_Start = 1'b1;
    tick();
    i_Frame_Start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (o_Has_Collided === 1'b1) begin
        if (r < 0) r = i;
        w++;
      end
      if (o_Busy === 1'b1) b = i;
      if (i == mv_at) set_car(0, 320, 384);
      i_Rst = (i == rst_at);
      tick();
    end
    i_Rst = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("reset_collided", int'(o_Has_Collided), 0);
    chk("reset_hit_car", int'(o_Hit_Car), 0);
    chk("reset_hit_count", int'(o_Hit_Count), 0);
    chk("reset_busy", int'(o_Busy), 0);
    set_car(3, 300, 384);
    run_frame(-1, -1, rise, width, busy_last);
    chk("car3_rise", rise, 5);
    chk("car3_width", width, 4);
    chk("car3_busy_last", busy_last, 8);
    chk("car3_hit_car", int'(o_Hit_Car), 3);
    chk("car3_hit_count", int'(o_Hit_Count), 1);
    hits = 0;
    for (int f = 0; f < 60; f++) begin
      run_frame(-1, -1, rise, width, busy_last);
      if (rise >= 0 || busy_last >= 0) hits++;
    end
    chk("grace_frames_active", hits, 0);
    chk("grace_hit_count", int'(o_Hit_Count), 1);
    run_frame(-1, -1, rise, width, busy_last);
    chk("after_grace_rise", rise, 5);
    chk("after_grace_hit_count", int'(o_Hit_Count), 2);
    do_reset();
    chk("reset2_hit_count", int'(o_Hit_Count), 0);
    chk("reset2_hit_car", int'(o_Hit_Car), 0);
    set_car(0, 352, 384);
    run_frame(-1, -1, rise, width, busy_last);
    chk("edge_touch_rise", rise, -1);
    chk("edge_touch_busy_last", busy_last, 8);
    chk("edge_touch_hit_count", int'(o_Hit_Count), 0);
    do_reset();
    set_car(2, 320, 384);
    set_car(5, 330, 390);
    run_frame(-1, -1, rise, width, busy_last);
    chk("two_cars_rise", rise, 4);
    chk("two_cars_width", width, 4);
    chk("two_cars_hit_car", int'(o_Hit_Car), 2);
    chk("two_cars_hit_count", int'(o_Hit_Count), 1);
    do_reset();
    run_frame(-1, 1, rise, width, busy_last);
    chk("snapshot_rise", rise, -1);
    run_frame(-1, -1, rise, width, busy_last);
    chk("snapshot_next_rise", rise, 2);
    chk("snapshot_next_hit_car", int'(o_Hit_Car), 0);
    do_reset();
    set_car(6, 320, 384);
    run_frame(5, -1, rise, width, busy_last);
    chk("rst_scan_rise", rise, -1);
    chk("rst_scan_busy_last", busy_last, 5);
    chk("rst_scan_hit_count", int'(o_Hit_Count), 0);
    chk("rst_scan_hit_car", int'(o_Hit_Car), 0);
    run_frame(-1, -1, rise, width, busy_last);
    chk("post_rst_rise", rise, 8);
    chk("post_rst_hit_car", int'(o_Hit_Car), 6);
    chk("post_rst_hit_count", int'(o_Hit_Count), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
